// File: rtl/keccak_theta_lane_stream.sv
// keccak_theta_lane_stream: lane-serial Keccak-f[1600] theta stage that buffers
// one 25-lane block, computes the column parities, then streams A^D with rho offsets.
module keccak_theta_lane_stream #(
    parameter int LANE_W  = 64,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANE_W-1:0]  in_lane,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANE_W-1:0]  out_lane,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_last,
    output logic               busy
);
    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;
    localparam logic [SHIFT_W-1:0] RHO [25] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };
    state_t            state, state_nx;
    logic [4:0]        cnt;
    logic [2:0]        col;
    logic [LANE_W-1:0] c [5];
    logic [LANE_W-1:0] d [5];
    logic [LANE_W-1:0] d_nx [5];
    logic [LANE_W-1:0] lanes [25];
    logic              in_fire, out_fire, last;
    assign last      = cnt == 5'd24;
    assign in_ready  = reset && state == LOAD;
    assign out_valid = state == EMIT;
    assign busy      = state != LOAD;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_lane  = out_valid ? lanes[cnt] ^ d[col] : '0;
    assign out_shift = out_valid ? RHO[cnt] : '0;
    assign out_last  = out_valid && last;
    // col tracks cnt mod 5 so no divider is needed on the lane index
    for (genvar x = 0; x < 5; x++) begin : g_d
        assign d_nx[x] = c[(x + 4) % 5] ^ {c[(x + 1) % 5][LANE_W-2:0], c[(x + 1) % 5][LANE_W-1]};
    end
    always_comb begin
        state_nx = state;
        if (state == LOAD && in_fire && last) state_nx = CALC;
        else if (state == CALC) state_nx = EMIT;
        else if (state == EMIT && out_fire && last) state_nx = LOAD;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            col   <= '0;
            c     <= '{default: '0};
            d     <= '{default: '0};
            lanes <= '{default: '0};
        end else begin
            if (in_fire) begin
                lanes[cnt] <= in_lane;
                c[col]     <= c[col] ^ in_lane;
            end
            if (state == CALC) d <= d_nx;
            if (in_fire || out_fire) begin
                cnt <= last ? '0 : cnt + 5'd1;
                col <= col == 3'd4 ? '0 : col + 3'd1;
            end
            if (out_fire && last) c <= '{default: '0};
        end
    end
endmodule

// File: tb/tb_keccak_theta_lane_stream.sv
// tb_keccak_theta_lane_stream: randomized bench comparing the lane stream
// against an array-based theta model computed from whole-state column parities.
module tb_keccak_theta_lane_stream;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [63:0] in_lane, out_lane;
    logic [5:0]  out_shift;
    int          compared = 0, mismatched = 0;
    int          got_n, first_valid, fed_ok;
    logic [63:0] blk [25];
    logic [63:0] exp_lane [25];
    logic [63:0] got_lane [25];
    logic [5:0]  got_shift [25];
    logic        got_last [25];
    localparam logic [5:0] RHO_REF [25] = '{
        6'd0, 6'd1, 6'd62, 6'd28, 6'd27, 6'd36, 6'd44, 6'd6, 6'd55, 6'd20,
        6'd3, 6'd10, 6'd43, 6'd25, 6'd39, 6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2, 6'd61, 6'd56, 6'd14
    };

    always #5 clk = ~clk;

    keccak_theta_lane_stream dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane(in_lane), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane(out_lane), .out_shift(out_shift), .out_last(out_last), .busy(busy)
    );

    task automatic model();
        logic [63:0] cp [5];
        logic [63:0] dp [5];
        for (int x = 0; x < 5; x++) begin
            cp[x] = 64'h0;
            for (int y = 0; y < 5; y++) cp[x] = cp[x] ^ blk[x + 5 * y];
        end
        for (int x = 0; x < 5; x++)
            dp[x] = cp[(x + 4) % 5] ^ ((cp[(x + 1) % 5] << 1) | (cp[(x + 1) % 5] >> 63));
        for (int i = 0; i < 25; i++) exp_lane[i] = blk[i] ^ dp[i % 5];
    endtask

    task automatic random_block();
        for (int i = 0; i < 25; i++) blk[i] = {$urandom, $urandom};
    endtask

    task automatic feed(input bit gaps);
        int  i = 0;
        int  cyc = 0;
        bit  fire;
        while (i < 25 && cyc < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_lane  = in_valid ? blk[i] : {$urandom, $urandom};
            fire     = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) i++;
            cyc++;
        end
        in_valid = 1'b0;
        fed_ok   = (i == 25);
    endtask

    task automatic recv(input int nmax);
        int cyc = 0;
        got_n       = 0;
        first_valid = -1;
        out_ready   = 1'b1;
        while (got_n < nmax && cyc < 2000) begin
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid) begin
                got_lane[got_n]  = out_lane;
                got_shift[got_n] = out_shift;
                got_last[got_n]  = out_last;
                got_n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_lane = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({out_valid, busy, out_last} !== 3'b000) begin
            mismatched++; $display("FAIL reset_flags: got valid/busy/last=%b want 000", {out_valid, busy, out_last});
        end
        compared++;
        if (out_lane !== 64'h0 || out_shift !== 6'h0) begin
            mismatched++; $display("FAIL reset_data: got lane=%h shift=%0d want 0/0", out_lane, out_shift);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 25; i++) blk[i] = 64'h0;
        feed(1'b0);
        compared++;
        if (fed_ok !== 1) begin mismatched++; $display("FAIL zero_feed: got timeout want 25 lanes"); end
        recv(25);
        compared++;
        if (first_valid !== 1) begin
            mismatched++; $display("FAIL zero_latency: got first valid cycle %0d want 1", first_valid);
        end
        compared++;
        if (got_n !== 25) begin mismatched++; $display("FAIL zero_count: got %0d want 25", got_n); end
        for (int i = 0; i < got_n; i++) begin
            compared++;
            if (got_lane[i] !== 64'h0 || got_shift[i] !== RHO_REF[i] || got_last[i] !== (i == 24)) begin
                mismatched++;
                $display("FAIL zero_lane%0d: got lane=%h shift=%0d last=%b want 0/%0d/%b",
                         i, got_lane[i], got_shift[i], got_last[i], RHO_REF[i], i == 24);
            end
        end
        compared++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            mismatched++; $display("FAIL zero_return: got ready/valid/busy=%b want 100", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_single_bit(input int idx);
        logic [63:0] want;
        int x;
        for (int i = 0; i < 25; i++) blk[i] = 64'h0;
        blk[idx] = (idx == 0) ? 64'h1 : 64'h8000_0000_0000_0000;
        feed(1'b1);
        recv(25);
        compared++;
        if (got_n !== 25) begin mismatched++; $display("FAIL bit%0d_count: got %0d want 25", idx, got_n); end
        for (int i = 0; i < got_n; i++) begin
            x = i % 5;
            if (idx == 0) want = (i == 0 || x == 1) ? 64'h1 : (x == 4) ? 64'h2 : 64'h0;
            else want = (x == 4 || i == 3) ? 64'h8000_0000_0000_0000 : (x == 2) ? 64'h1 : 64'h0;
            compared++;
            if (got_lane[i] !== want) begin
                mismatched++; $display("FAIL bit%0d_lane%0d: got %h want %h", idx, i, got_lane[i], want);
            end
        end
    endtask

    task automatic test_stall();
        int          cyc = 0;
        int          r = 0;
        bit          prev_stall = 1'b0;
        logic [63:0] pl;
        logic [5:0]  ps;
        logic        plast;
        random_block();
        model();
        feed(1'b1);
        compared++;
        if (fed_ok !== 1) begin mismatched++; $display("FAIL stall_feed: got timeout want 25 lanes"); end
        compared++;
        if ({in_ready, busy, out_valid} !== 3'b010) begin
            mismatched++; $display("FAIL stall_calc: got ready/busy/valid=%b want 010", {in_ready, busy, out_valid});
        end
        while (r < 25 && cyc < 2000) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = $urandom_range(0, 1);
            in_lane   = {$urandom, $urandom};
            compared++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                mismatched++; $display("FAIL stall_ready_c%0d: got ready=%b busy=%b want 0/1", cyc, in_ready, busy);
            end
            if (prev_stall) begin
                compared++;
                if (out_valid !== 1'b1 || out_lane !== pl || out_shift !== ps || out_last !== plast) begin
                    mismatched++;
                    $display("FAIL stall_hold_c%0d: got v=%b lane=%h shift=%0d want 1 lane=%h shift=%0d",
                             cyc, out_valid, out_lane, out_shift, pl, ps);
                end
            end
            prev_stall = out_valid && !out_ready;
            pl = out_lane; ps = out_shift; plast = out_last;
            if (out_valid && out_ready) begin
                compared++;
                if (out_lane !== exp_lane[r] || out_shift !== RHO_REF[r] || out_last !== (r == 24)) begin
                    mismatched++;
                    $display("FAIL stall_lane%0d: got %h/%0d/%b want %h/%0d/%b", r, out_lane, out_shift,
                             out_last, exp_lane[r], RHO_REF[r], r == 24);
                end
                r++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        compared++;
        if (r !== 25) begin mismatched++; $display("FAIL stall_count: got %0d want 25", r); end
    endtask

    task automatic test_reset_mid();
        random_block();
        feed(1'b1);
        recv(11);
        reset = 1'b0;
        #1;
        compared++;
        if ({out_valid, busy, out_last} !== 3'b000 || out_lane !== 64'h0 || out_shift !== 6'h0) begin
            mismatched++;
            $display("FAIL mid_reset_outputs: got v/b/l=%b lane=%h shift=%0d want 000/0/0",
                     {out_valid, busy, out_last}, out_lane, out_shift);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_reset_ready: got %b want 1", in_ready); end
        random_block();
        model();
        feed(1'b1);
        recv(25);
        compared++;
        if (got_n !== 25) begin mismatched++; $display("FAIL mid_count: got %0d want 25", got_n); end
        for (int i = 0; i < got_n; i++) begin
            compared++;
            if (got_lane[i] !== exp_lane[i] || got_shift[i] !== RHO_REF[i]) begin
                mismatched++; $display("FAIL mid_lane%0d: got %h/%0d want %h/%0d", i, got_lane[i],
                                       got_shift[i], exp_lane[i], RHO_REF[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] all [50];
        logic [63:0] gl [50];
        logic        glast [50];
        int          s = 0;
        int          r = 0;
        int          cyc = 0;
        bit          fin;
        for (int i = 0; i < 50; i++) all[i] = {$urandom, $urandom};
        out_ready = 1'b1;
        while (r < 50 && cyc < 3000) begin
            in_valid = (s < 50);
            in_lane  = (s < 50) ? all[s] : 64'h0;
            fin      = in_valid && in_ready;
            if (fin && s == 25) begin
                compared++;
                if (r < 25) begin
                    mismatched++; $display("FAIL b2b_overlap: got second block accepted after %0d outputs want 25", r);
                end
            end
            if (out_valid) begin
                gl[r] = out_lane; glast[r] = out_last; r++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fin) s++;
        end
        in_valid = 1'b0;
        compared++;
        if (r !== 50) begin mismatched++; $display("FAIL b2b_count: got %0d want 50", r); end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 25; i++) blk[i] = all[25 * b + i];
            model();
            for (int i = 0; i < 25 && 25 * b + i < r; i++) begin
                compared++;
                if (gl[25 * b + i] !== exp_lane[i] || glast[25 * b + i] !== (i == 24)) begin
                    mismatched++; $display("FAIL b2b_blk%0d_lane%0d: got %h/%b want %h/%b", b, i,
                                           gl[25 * b + i], glast[25 * b + i], exp_lane[i], i == 24);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_bit(0);
        test_single_bit(3);
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
